// File: rtl/fp32_to_fp16_pipe.sv
// fp32_to_fp16_pipe: two-stage binary32 -> binary16 narrowing converter with RNE rounding,
// valid/ready handshakes, per-result and sticky {OF, UF, NX} flags.
module fp32_to_fp16_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_flags,
    input  logic        flags_clr,
    output logic [2:0]  sticky_flags
);
    typedef enum logic [1:0] {CL_FIN, CL_NAN, CL_INF, CL_OVF} cls_t;

    logic [7:0]  ex;
    logic [22:0] mf;
    logic [8:0]  e_d;
    logic [4:0]  sh;
    logic [34:0] wide;
    cls_t        cls_d, cls1_q;
    logic [4:0]  exp1_d, exp1_q;
    logic [9:0]  mant1_d, mant1_q;
    logic        g1_d, g1_q, st1_d, st1_q, tiny1_d, tiny1_q, s1_q;
    logic        v1_q, v1_d, v2_q, adv2, in_fire;
    logic        inc, nx;
    logic [14:0] sum;
    logic [15:0] data2_d, data2_q;
    logic [2:0]  flags2_d, flags2_q, sflags_d, sflags_q;

    assign ex   = in_data[30:23];
    assign mf   = in_data[22:0];
    assign e_d  = {1'b0, ex} - 9'd112;
    assign sh   = (ex <= 8'd101) ? 5'd25 : 5'(8'd126 - ex);
    // bit 24 of the shifted significand is the guard bit, bits below it feed sticky
    assign wide = 35'({1'b1, mf, 25'h0} >> sh);

    always_comb begin
        cls_d   = CL_FIN;
        mant1_d = mf[22:13];
        g1_d    = mf[12];
        st1_d   = |mf[11:0];
        tiny1_d = 1'b0;
        exp1_d  = e_d[4:0];
        if (ex == 8'hFF) begin
            cls_d   = (mf != 23'h0) ? CL_NAN : CL_INF;
            mant1_d = {mf != 23'h0, mf[21:13]};
            g1_d    = 1'b0;
            st1_d   = 1'b0;
        end else if (ex == 8'h00) begin
            mant1_d = 10'h0;
            g1_d    = 1'b0;
            st1_d   = |mf;
            tiny1_d = 1'b1;
            exp1_d  = 5'h0;
        end else if ($signed(e_d) >= 9'sd31) begin
            cls_d = CL_OVF;
        end else if ($signed(e_d) < 9'sd1) begin
            mant1_d = wide[34:25];
            g1_d    = wide[24];
            st1_d   = |wide[23:0];
            tiny1_d = 1'b1;
            exp1_d  = 5'h0;
        end
    end

    assign adv2     = !v2_q | out_ready;
    assign in_ready = !v1_q | adv2;
    assign in_fire  = in_valid & in_ready;
    assign v1_d     = in_fire ? 1'b1 : (adv2 ? 1'b0 : v1_q);

    // a carry out of the mantissa bumps the exponent, covering subnormal->normal too
    assign inc = g1_q & (st1_q | mant1_q[0]);
    assign sum = {exp1_q, mant1_q} + {14'h0, inc};
    assign nx  = g1_q | st1_q;

    always_comb begin
        data2_d  = {s1_q, sum};
        flags2_d = {1'b0, tiny1_q & nx, nx};
        if (cls1_q == CL_NAN || cls1_q == CL_INF) begin
            data2_d  = {s1_q, 5'h1F, mant1_q};
            flags2_d = 3'b000;
        end else if (cls1_q == CL_OVF || sum[14:10] == 5'h1F) begin
            data2_d  = {s1_q, 5'h1F, 10'h0};
            flags2_d = 3'b101;
        end
    end

    assign sflags_d = (flags_clr ? 3'b000 : sflags_q) | ((v2_q & out_ready) ? flags2_q : 3'b000);

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_q    <= in_data[31];
            cls1_q  <= cls_d;
            exp1_q  <= exp1_d;
            mant1_q <= mant1_d;
            g1_q    <= g1_d;
            st1_q   <= st1_d;
            tiny1_q <= tiny1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            data2_q  <= 16'h0;
            flags2_q <= 3'b000;
            sflags_q <= 3'b000;
        end else begin
            v1_q     <= v1_d;
            sflags_q <= sflags_d;
            if (adv2) v2_q <= v1_q;
            if (adv2 && v1_q) begin
                data2_q  <= data2_d;
                flags2_q <= flags2_d;
            end
        end
    end

    assign out_valid    = v2_q;
    assign out_data     = data2_q;
    assign out_flags    = flags2_q;
    assign sticky_flags = sflags_q;
endmodule

// File: tb/tb_fp32_to_fp16_pipe.sv
// tb_fp32_to_fp16_pipe: directed vectors with hand-computed FP16 results and flags,
// streamed through the handshakes with in-order scoreboarding.
module tb_fp32_to_fp16_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        flags_clr = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [2:0]  out_flags, sticky_flags;

    int n_tests = 0;
    int n_fail = 0;
    int lr;
    int src_q[$];
    bit rdy_pat[$];

    // expected entries are {OF, UF, NX, fp16}
    logic [31:0] vin [16] = '{
        32'h3F800000, 32'hC0490FDB, 32'h477FE000, 32'h477FF000,
        32'h7F7FFFFF, 32'hFF800000, 32'h7FC00001, 32'h33800000,
        32'h33000000, 32'h33000001, 32'h387FC000, 32'h387FE000,
        32'h387FF000, 32'h00000001, 32'h80000000, 32'h38800000};
    logic [18:0] vexp [16] = '{
        {3'b000, 16'h3C00}, {3'b001, 16'hC248}, {3'b000, 16'h7BFF}, {3'b101, 16'h7C00},
        {3'b101, 16'h7C00}, {3'b000, 16'hFC00}, {3'b000, 16'h7E00}, {3'b000, 16'h0001},
        {3'b011, 16'h0000}, {3'b011, 16'h0001}, {3'b000, 16'h03FF}, {3'b011, 16'h0400},
        {3'b011, 16'h0400}, {3'b011, 16'h0000}, {3'b000, 16'h8000}, {3'b000, 16'h0400}};

    fp32_to_fp16_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
        .flags_clr(flags_clr), .sticky_flags(sticky_flags));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input string tag, input bit lat_chk, output int low_rdy);
        int sent = 0, got = 0, cyc = 0, n = src_q.size();
        int in_cyc[$];
        bit stall = 0;
        logic [18:0] hold = '0;
        low_rdy = 0;
        while (got < n && cyc < 300) begin
            tick();
            if (stall) begin
                check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_stall_hold"}, 32'({out_flags, out_data}), 32'(hold));
            end
            in_valid  = sent < n;
            in_data   = (sent < n) ? vin[src_q[sent]] : 32'h0;
            out_ready = rdy_pat[cyc % rdy_pat.size()];
            #1;
            if (!in_ready) low_rdy++;
            if (out_valid && out_ready) begin
                if (in_cyc.size() == 0) check({tag, "_extra_out"}, 32'd1, 32'd0);
                else begin
                    check($sformatf("%s_res%0d", tag, got), 32'({out_flags, out_data}),
                          32'(vexp[src_q[got]]));
                    if (lat_chk) check({tag, "_latency"}, 32'(cyc - in_cyc[0]), 32'd2);
                    void'(in_cyc.pop_front());
                end
                got++;
            end
            stall = out_valid && !out_ready;
            hold  = {out_flags, out_data};
            if (in_valid && in_ready) begin
                in_cyc.push_back(cyc);
                sent++;
            end
            cyc++;
        end
        check({tag, "_delivered"}, 32'(got), 32'(n));
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'({out_flags, out_data}), 32'd0);
        check("rst_sticky", 32'(sticky_flags), 32'd0);

        rdy_pat = {1'b1};
        src_q = {0, 1, 2};
        run_stream("basic", 1, lr);
        check("basic_no_stall", 32'(lr), 32'd0);
        src_q = {3, 4, 5, 6};
        run_stream("ovf", 1, lr);
        src_q = {7, 8, 9, 10, 11, 12, 13, 14, 15};
        run_stream("sub", 1, lr);

        rdy_pat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        src_q = {1, 8, 3, 10, 6, 11};
        run_stream("bp", 0, lr);
        check("bp_inready_drop", 32'(lr != 0), 32'd1);
        rdy_pat = {1'b1};

        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_alone", 32'(sticky_flags), 32'd0);
        src_q = {4, 8};
        run_stream("stk", 0, lr);
        check("sticky_acc", 32'(sticky_flags), 32'b111);

        in_valid  = 1'b1;
        in_data   = vin[1];
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_hs_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_with_hs", 32'(sticky_flags), 32'b001);
        check("clr_hs_drained", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vin[0];
        tick();
        in_data = vin[2];
        tick();
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out", 32'({out_flags, out_data}), 32'd0);
        check("mrst_sticky", 32'(sticky_flags), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        src_q = {5};
        run_stream("post_rst", 1, lr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
